// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - instruction fetch: PC, single-outstanding memory read, prefetch FIFO, redirect
module instr_fetch_unit #(
  parameter int                ADDR_W   = 8,
  parameter int                INSTR_W  = 16,
  parameter int                DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr_data,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               instr_ready,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;

  state_t             state, state_nxt;
  logic [ADDR_W-1:0]  fetch_pc, fetch_pc_nxt, mem_addr_nxt;
  logic [CW-1:0]      count, count_after;
  logic [PW-1:0]      rd_ptr, wr_ptr;
  logic [INSTR_W-1:0] data_mem [DEPTH];
  logic [ADDR_W-1:0]  pc_mem   [DEPTH];
  logic               push, pop, can_issue;

  assign instr_valid = (count != '0);
  assign instr_data  = data_mem[rd_ptr];
  assign instr_pc    = pc_mem[rd_ptr];

  // A redirect flushes the FIFO, so it suppresses both the push and the pop.
  assign pop       = instr_valid && instr_ready && !redirect;
  assign push      = (state == WAIT) && mem_ack && !redirect;
  assign can_issue = enable && (count < DEPTH_C) && !redirect;

  always_comb begin
    count_after = count + CW'(push) - CW'(pop);
  end

  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    mem_addr_nxt = mem_addr;
    case (state)
      IDLE: begin
        if (redirect) begin
          fetch_pc_nxt = redirect_pc;
        end else if (can_issue) begin
          state_nxt    = WAIT;
          mem_addr_nxt = fetch_pc;
        end
      end
      WAIT: begin
        if (redirect) begin
          fetch_pc_nxt = redirect_pc;
          if (!mem_ack) begin
            state_nxt = DISCARD;
          end else if (enable) begin
            mem_addr_nxt = redirect_pc;
          end else begin
            state_nxt = IDLE;
          end
        end else if (mem_ack) begin
          fetch_pc_nxt = mem_addr + ADDR_W'(1);
          if (enable && (count_after < DEPTH_C)) begin
            mem_addr_nxt = mem_addr + ADDR_W'(1);
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      DISCARD: begin
        if (redirect) begin
          fetch_pc_nxt = redirect_pc;
        end
        // The stale word is dropped; restart from the redirected fetch_pc.
        if (mem_ack) begin
          if (enable && !redirect) begin
            state_nxt    = WAIT;
            mem_addr_nxt = fetch_pc;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      mem_req  <= 1'b0;
      mem_addr <= RESET_PC;
      fetch_pc <= RESET_PC;
    end else begin
      state    <= state_nxt;
      mem_req  <= (state_nxt != IDLE);
      mem_addr <= mem_addr_nxt;
      fetch_pc <= fetch_pc_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_mem[i] <= '0;
        pc_mem[i]   <= '0;
      end
    end else if (redirect) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) begin
        data_mem[wr_ptr] <= mem_rdata;
        pc_mem[wr_ptr]   <= mem_addr;
        wr_ptr           <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count_after;
    end
  end

  a_no_push_when_full: assert property (@(posedge clk) disable iff (!reset_n)
    !(push && (count == DEPTH_C)));

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Instruction fetch stage sitting directly upstream of CU_EU. Holds the program counter and issues one read at a time to instruction memory over a req/ack handshake. Buffers returned words with their PCs in a small FIFO and presents them to CU_EU over a valid/ready interface. Supports a branch redirect from CU_EU that flushes the buffer and drops any in-flight fetch.

Parameters:
ADDR_W, 8, instruction address width; PC wraps modulo 2^ADDR_W
INSTR_W, 16, instruction word width
DEPTH, 2, prefetch FIFO entries; power of two, minimum 2
RESET_PC, 0, PC value loaded at reset

Ports:
clk  in  1  single system clock, rising edge
reset_n  in  1  asynchronous, active-low reset
enable  in  1  fetch enable, driven from enableCU; low = issue no new requests
mem_req  out  1  read request to instruction memory; registered
mem_addr  out  ADDR_W  read address; stable while mem_req high
mem_ack  in  1  read completion; mem_rdata valid in the same cycle
mem_rdata  in  INSTR_W  returned instruction word
instr_valid  out  1  FIFO head valid toward CU_EU
instr_data  out  INSTR_W  FIFO head instruction
instr_pc  out  ADDR_W  address of the FIFO head instruction
instr_ready  in  1  CU_EU accepts the head this cycle
redirect  in  1  branch taken; one-cycle pulse
redirect_pc  in  ADDR_W  new fetch address, sampled when redirect=1

Behaviour:
- Reset (async assert, sync release):
  - mem_req=0, mem_addr=RESET_PC, fetch_pc=RESET_PC.
  - FIFO count=0, instr_valid=0, instr_data=0, instr_pc=0.
  - state=IDLE.
- States: IDLE (no outstanding request), WAIT (request outstanding), DISCARD (outstanding request whose data is dropped).
- Issue condition: enable=1, count<DEPTH, redirect=0.
- IDLE:
  - If the issue condition holds, go to WAIT next cycle with mem_req=1 and mem_addr=fetch_pc.
  - redirect=1: fetch_pc<=redirect_pc, FIFO flushed, stay IDLE for that cycle.
- WAIT:
  - mem_req and mem_addr are held until mem_ack. A request is never retracted, not even when enable drops.
  - On mem_ack without redirect: push {mem_rdata, mem_addr}, fetch_pc<=mem_addr+1 (wraps).
  - If, after the push and any same-cycle pop, count<DEPTH and enable=1: stay WAIT with mem_addr=mem_addr+1, so back-to-back requests are allowed.
  - Otherwise go to IDLE with mem_req=0.
- Redirect in WAIT:
  - Redirect without mem_ack: go to DISCARD. mem_req stays high with the old address; fetch_pc<=redirect_pc; FIFO flushed.
  - Redirect with mem_ack: the returned word is dropped and the FIFO flushed. Next state is WAIT at redirect_pc if enable=1, else IDLE.
- DISCARD:
  - On mem_ack, drop the data.
  - Next state is WAIT at fetch_pc if enable=1 and redirect=0, else IDLE.
  - Another redirect while in DISCARD updates fetch_pc only.
- FIFO:
  - instr_valid = (count!=0); instr_data and instr_pc show the head entry.
  - Pop when instr_valid && instr_ready.
  - Push and pop in the same cycle leave count unchanged.
  - A push when full cannot occur because the issue condition prevents it. Verify this with an assertion.
  - Pointers wrap modulo DEPTH.
- Priority: redirect flush beats push and pop in the same cycle. instr_valid=0 in the cycle after a redirect.
- Latency:
  - enable rising in IDLE with an empty FIFO gives mem_req=1 the next cycle.
  - mem_ack in cycle N gives instr_valid=1 in cycle N+1.
- Reset mid-operation: all state is cleared immediately. A mem_ack arriving after reset release while in IDLE is ignored.
- enable=0 only stops new issues. The outstanding request completes and the FIFO continues to drain.

Test Plan:
- Reset, enable=1, memory ack latency 1, instr_ready=1 -> mem_addr sequence 0,1,2,...; instr_pc follows with 1-cycle lag after each ack; data matches memory contents.
- instr_ready=0 with DEPTH=2 -> exactly 2 words buffered, mem_req stays 0; raise ready -> pc 0, 1 popped, then fetch resumes at 2.
- Ack latency 3, redirect to 0x40 pulsed one cycle after mem_req -> mem_req held until ack, that word is not pushed, next mem_addr=0x40, first instr_pc=0x40.
- Redirect to 0x10 coincident with mem_ack and instr_ready=1 while the FIFO holds 1 entry -> no push, no pop output, instr_valid=0 next cycle, next fetch at 0x10.
- PC wrap: redirect to 0xFE, ADDR_W=8 -> addresses 0xFE, 0xFF, 0x00.
- Deassert reset_n while in WAIT with 1 entry buffered -> outputs reset asynchronously; after release, fetch restarts at RESET_PC and a late mem_ack is ignored.
